// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit -- program-counter stage feeding the instruction fetch block.
//
// Holds the architectural PC, picks the next PC from sequential flow,
// conditional branches, jal and jalr, and drives the instruction-memory word
// address from the next-PC value. The memory reads synchronously, so the word
// it returns lines up with the registered PC one cycle later. Also provides
// RUN/HALT/FAULT control and a retired-instruction counter.
//
// Ports
//   clk          in   1   system clock, rising edge
//   rst          in   1   asynchronous, active-high reset
//   stall        in   1   hold the PC and all state this cycle
//   branch       in   1   current instruction is a conditional branch
//   funct3       in   3   branch condition select
//   zero         in   1   rs1 == rs2
//   lt           in   1   signed rs1 < rs2
//   ltu          in   1   unsigned rs1 < rs2
//   jal          in   1   current instruction is jal
//   jalr         in   1   current instruction is jalr
//   imm          in  32   sign-extended immediate
//   rs1_data     in  32   jalr base register value
//   halt_req     in   1   current instruction is ecall/halt
//   resume       in   1   leave HALT
//   pc           out 32   registered PC of the current instruction
//   pc_plus4     out 32   pc + 4 (link value)
//   imem_addr    out 14   next_pc[15:2] to instruction memory
//   halted       out  1   state is HALT
//   fault        out  1   state is FAULT
//   fault_target out 32   illegal target captured on entry to FAULT
//   instret      out 32   retired-instruction count
// ---------------------------------------------------------------------------
module pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_LIMIT = 32'h0001_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        branch,
   input  logic [2:0]  funct3,
   input  logic        zero,
   input  logic        lt,
   input  logic        ltu,
   input  logic        jal,
   input  logic        jalr,
   input  logic [31:0] imm,
   input  logic [31:0] rs1_data,
   input  logic        halt_req,
   input  logic        resume,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [13:0] imem_addr,
   output logic        halted,
   output logic        fault,
   output logic [31:0] fault_target,
   output logic [31:0] instret
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HALT  = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;

   logic        taken;
   logic [31:0] jalr_sum;
   logic [31:0] target;
   logic        illegal;
   logic        advance;      // RUN, not stalled, legal target: instruction retires
   logic        enter_fault;  // RUN, not stalled, illegal target
   logic [31:0] next_pc;
   logic [31:0] pc_d;

   assign pc_plus4 = pc + 32'd4;
   assign jalr_sum = rs1_data + imm;

   // ------------------------------------------------------------------------
   // Branch condition decode. 010/011 are not branch encodings: never taken.
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable written in a combinational block gets a default
      // first, so no path leaves it unassigned and no latch is inferred.
      taken = 1'b0;
      case (funct3)
         3'b000:  taken = zero;
         3'b001:  taken = !zero;
         3'b100:  taken = lt;
         3'b101:  taken = !lt;
         3'b110:  taken = ltu;
         3'b111:  taken = !ltu;
         default: taken = 1'b0;
      endcase
   end

   // ------------------------------------------------------------------------
   // Target selection: jalr > jal > taken branch > pc+4.
   // ------------------------------------------------------------------------
   always_comb begin
      target = pc_plus4;
      if (jalr)
         target = jalr_sum & 32'hFFFF_FFFE;
      else if (jal || (branch && taken))
         target = pc + imm;
   end

   // A sequential pc+4 hitting PC_LIMIT is caught by the same compare.
   assign illegal = target[1] || (target >= PC_LIMIT);

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state is written with non-blocking assignments so
      // every flop samples the values from before this edge.
      if (rst)
         state <= ST_RUN;
      else
         state <= state_next;
   end

   // ------------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_next = state;
      case (state)
         ST_RUN: begin
            if (!stall) begin
               if (illegal)
                  state_next = ST_FAULT;   // fault outranks halt_req
               else if (halt_req)
                  state_next = ST_HALT;
            end
         end
         ST_HALT: begin
            if (resume && !stall)
               state_next = ST_RUN;        // resume outranks halt_req
         end
         ST_FAULT: state_next = ST_FAULT;  // only rst leaves FAULT
         default:  state_next = ST_RUN;
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: outputs and datapath enables
   // ------------------------------------------------------------------------
   always_comb begin
      halted      = 1'b0;
      fault       = 1'b0;
      advance     = 1'b0;
      enter_fault = 1'b0;
      case (state)
         ST_RUN: begin
            advance     = !stall && !illegal;
            enter_fault = !stall && illegal;
         end
         ST_HALT:  halted = 1'b1;
         ST_FAULT: fault  = 1'b1;
         default: ;
      endcase
   end

   // ------------------------------------------------------------------------
   // Next PC and memory address. While reset is held the address already
   // points at RESET_PC so the first fetch after release is correct.
   // ------------------------------------------------------------------------
   assign next_pc   = advance ? target : pc;
   assign imem_addr = rst ? RESET_PC[15:2] : next_pc[15:2];

   // A halting instruction always retires to pc+4.
   assign pc_d = (advance && halt_req) ? pc_plus4 : next_pc;

   // ------------------------------------------------------------------------
   // Architectural registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc           <= RESET_PC;
         instret      <= 32'd0;
         fault_target <= 32'd0;
      end else begin
         pc <= pc_d;
         if (advance)
            instret <= instret + 32'd1;   // wraps naturally at 2^32
         if (enter_fault)
            fault_target <= target;
      end
   end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Program-counter stage directly upstream of the instruction fetch block.
- Holds the architectural PC and resolves the next PC from sequential flow, conditional branches, jal and jalr.
- Drives the 14-bit word address into instruction memory. Because that memory reads synchronously, the address comes from the next-PC value, so the fetched instruction lines up with the registered PC.
- Provides run/halt/fault control and a retired-instruction counter.

Parameters:
- RESET_PC, 32'h0000_0000: byte address loaded into the PC on reset.
- PC_LIMIT, 32'h0001_0000: exclusive upper bound of legal instruction byte addresses; equals 16K words × 4.

Ports:
- clk  in  1  system clock; rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold the PC and all state this cycle.
- branch  in  1  current instruction is a conditional branch.
- funct3  in  3  branch condition select.
- zero  in  1  ALU result equals zero (rs1 == rs2).
- lt  in  1  signed rs1 < rs2.
- ltu  in  1  unsigned rs1 < rs2.
- jal  in  1  current instruction is jal.
- jalr  in  1  current instruction is jalr.
- imm  in  32  sign-extended immediate.
- rs1_data  in  32  register rs1 value (jalr base).
- halt_req  in  1  current instruction is ecall/halt.
- resume  in  1  leave HALT state.
- pc  out  32  registered PC of the current instruction.
- pc_plus4  out  32  pc + 4; the link value.
- imem_addr  out  14  next_pc[15:2], to instruction memory.
- halted  out  1  state == HALT.
- fault  out  1  state == FAULT.
- fault_target  out  32  offending target, captured on entry to FAULT.
- instret  out  32  count of retired instructions.

Behaviour:
- Reset (async, rst=1):
  - pc = RESET_PC; state = RUN; halted = 0; fault = 0; fault_target = 0; instret = 0.
  - While rst=1, next_pc = RESET_PC, so imem_addr = RESET_PC[15:2].
- Branch taken, by funct3: 000 → zero; 001 → !zero; 100 → lt; 101 → !lt; 110 → ltu; 111 → !ltu; 010 and 011 → never taken.
- Target arithmetic, all 32-bit and wrapping:
  - jalr: (rs1_data + imm) & ~1.
  - jal or taken branch: pc + imm.
- Redirect priority: jalr > jal > taken branch > pc+4.
- Target illegal when bit[1] = 1 or target >= PC_LIMIT (unsigned). A sequential pc+4 reaching PC_LIMIT is also illegal.
- next_pc, combinational:
  - equals pc when stall=1, or state is HALT or FAULT, or the selected target is illegal;
  - otherwise equals the selected target.
  - In HALT with resume=1 and stall=0: next_pc = pc.
- imem_addr = next_pc[15:2] every cycle.
- States:
  - RUN:
    - stall=1 → hold everything, including instret; halt_req and redirects are ignored.
    - Else illegal target → FAULT; fault_target <= the illegal target; pc holds. Fault takes priority over halt_req.
    - Else halt_req → HALT; pc <= pc+4; instret += 1.
    - Else pc <= next_pc; instret += 1.
  - HALT:
    - pc holds; branch/jump inputs are ignored.
    - resume=1 and stall=0 → RUN, with no PC change that cycle.
    - resume and halt_req both high → resume wins.
  - FAULT: sticky; only rst exits. pc, fault_target and instret all hold.
- pc_plus4 = pc + 4 combinationally, wrapping at 2^32.
- instret wraps from 32'hFFFF_FFFF to 0.
- Reset asserted mid-operation (any state, any stall) → immediate return to reset values.
- Single-cycle latency: a redirect decided in cycle N gives pc = target in cycle N+1, and imem_addr already shows the target in cycle N.

Test Plan:
1. Reset then free run 4 cycles, no control inputs → pc = 0, 4, 8, 12; imem_addr during cycle 0 = 1; instret = 4.
2. pc = 0x20, branch=1, funct3=000, zero=1, imm = -8 → next pc = 0x18. Same stimulus with funct3=001 → next pc = 0x24. With funct3=110, ltu=1, imm = 0x40 → next pc = 0x60.
3. jal=1 and jalr=1 together, rs1_data = 0x101, imm = 3, pc = 0x10 → pc = 0x104 (jalr wins; bit0 cleared).
4. stall=1 for 3 cycles alongside jal, imm = 0x100 → pc and instret unchanged; redirect applied on the first cycle with stall=0.
5. jal with imm giving target 0x0001_0000 → fault = 1, fault_target = 0x0001_0000, pc holds. Stays faulted across resume; rst clears it.
6. halt_req at pc = 0x40 → halted = 1, pc = 0x44. Hold 5 cycles with branch inputs toggling → pc stays 0x44. resume=1 → RUN, and the next cycle pc = 0x48.
